dino_game_physics: RTL and testbench



---
 rtl/dino_game_pkg.sv | 33 +++
 rtl/dino_game_physics_edge.sv | 45 ++++
 rtl/dino_game_physics.sv | 185 ++++++++++++++++++
 tb/tb_dino_game_physics.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dino_game_pkg.sv
// Shared types and default constants for the dino game physics engine.
package dino_game_pkg;

    localparam int unsigned COORD_W          = 12;
    localparam int unsigned VEL_W            = 8;
    localparam int unsigned SCORE_W          = 16;
    localparam int unsigned SPEED_W          = 4;
    localparam int unsigned SPEED_MAX        = 12;

    localparam int unsigned DINO_X_DEF       = 100;
    localparam int unsigned GROUND_Y_DEF     = 320;
    localparam int unsigned OBST_START_X_DEF = 680;
    localparam int unsigned OBST_SPEED_DEF   = 4;
    localparam int unsigned JUMP_VEL_DEF     = 14;
    localparam int unsigned GRAVITY_DEF      = 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        GAME_OVER = 2'd2
    } game_state_t;

    typedef enum logic {
        GROUND = 1'b0,
        AIR    = 1'b1
    } jump_state_t;

    // Increment that sticks at all-ones.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == '1) ? v : v + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/dino_game_physics_edge.sv
// edge_pulse: optional 2-flop synchronizer followed by a registered
// rising-edge detector producing a one-clock pulse.
module edge_pulse #(
    parameter bit SYNC_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic pulse_o
);

    logic sig_s;
    logic prev_q;
    logic pulse_q;

    if (SYNC_EN) begin : g_sync
        logic sync1_q;
        logic sync2_q;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
            end else begin
                sync1_q <= sig_i;
                sync2_q <= sync1_q;
            end
        end
        assign sig_s = sync2_q;
    end else begin : g_nosync
        assign sig_s = sig_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= sig_s;
            pulse_q <= sig_s & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/dino_game_physics.sv
// Per-frame dino game-state engine: jump physics, obstacle scroll, score.
// Optional macro SPEEDUP_EN: obstacle speed grows every 8 points, capped at 12.
module dino_game_physics
    import dino_game_pkg::*;
#(
    parameter int unsigned DINO_X       = DINO_X_DEF,
    parameter int unsigned GROUND_Y     = GROUND_Y_DEF,
    parameter int unsigned OBST_START_X = OBST_START_X_DEF,
    parameter int unsigned OBST_SPEED   = OBST_SPEED_DEF,
    parameter int unsigned JUMP_VEL     = JUMP_VEL_DEF,
    parameter int unsigned GRAVITY      = GRAVITY_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        screen_ready,
    input  logic        collision_detected,
    input  logic        jump_btn,
    output logic [31:0] x_coor,
    output logic [31:0] y_coor,
    output logic [31:0] x_coor_obstacle,
    output logic [31:0] y_coor_obstacle,
    output logic        game_over,
    output logic [15:0] score
);

    localparam logic [COORD_W-1:0]      GROUND_C   = COORD_W'(GROUND_Y);
    localparam logic [COORD_W-1:0]      START_C    = COORD_W'(OBST_START_X);
    localparam logic signed [COORD_W:0] GROUND_S   = (COORD_W+1)'(GROUND_Y);
    localparam logic signed [VEL_W-1:0] JUMP_S     = VEL_W'(JUMP_VEL);
    localparam logic signed [VEL_W-1:0] GRAV_S     = VEL_W'(GRAVITY);
    localparam logic [SPEED_W-1:0]      SPEED_INIT = SPEED_W'(OBST_SPEED);

    logic frame_tick;
    logic jump_pulse;

    edge_pulse #(.SYNC_EN(1'b1)) u_jump_edge (
        .clk     (clk),
        .rst_n   (reset),
        .sig_i   (jump_btn),
        .pulse_o (jump_pulse)
    );

    edge_pulse #(.SYNC_EN(1'b0)) u_frame_edge (
        .clk     (clk),
        .rst_n   (reset),
        .sig_i   (screen_ready),
        .pulse_o (frame_tick)
    );

    game_state_t               game_q, game_d;
    jump_state_t               jump_q, jump_d;
    logic signed [VEL_W-1:0]   vel_q, vel_d;
    logic [COORD_W-1:0]        y_q, y_d;
    logic [COORD_W-1:0]        x_q, x_d;
    logic [SCORE_W-1:0]        score_q, score_d;
    logic                      game_over_q, game_over_d;
    logic                      jump_req_q, jump_req_d;
    logic [SPEED_W-1:0]        speed_cur;

`ifdef SPEEDUP_EN
    logic [SPEED_W-1:0]        speed_q, speed_d;
    assign speed_cur = speed_q;
`else
    assign speed_cur = SPEED_INIT;
`endif

    logic signed [VEL_W-1:0]   vel_eff;
    logic signed [COORD_W:0]   y_calc;
    logic [SCORE_W-1:0]        score_inc;
    logic                      go;

    // Next-state logic for game flow, jump physics and obstacle scroll.
    always_comb begin
        game_d      = game_q;
        jump_d      = jump_q;
        vel_d       = vel_q;
        y_d         = y_q;
        x_d         = x_q;
        score_d     = score_q;
        game_over_d = game_over_q;
        jump_req_d  = jump_req_q;
`ifdef SPEEDUP_EN
        speed_d     = speed_q;
`endif
        vel_eff     = vel_q;
        y_calc      = '0;
        score_inc   = sat_inc(score_q);
        go          = 1'b0;

        unique case (game_q)
            IDLE: begin
                if (jump_pulse) game_d = RUN;
            end
            RUN: begin
                if (collision_detected) begin
                    game_d      = GAME_OVER;
                    game_over_d = 1'b1;
                end else begin
                    if (jump_pulse && jump_q == GROUND) jump_req_d = 1'b1;
                    if (frame_tick) begin
                        jump_req_d = 1'b0;
                        go         = (jump_q == GROUND) && (jump_req_q || jump_pulse);
                        vel_eff    = go ? JUMP_S : vel_q;
                        if (go || jump_q == AIR) begin
                            // Signed 13-bit so an upward vel never wraps y.
                            y_calc = $signed({1'b0, y_q}) - (COORD_W+1)'(vel_eff);
                            if (y_calc >= GROUND_S) begin
                                y_d    = GROUND_C;
                                vel_d  = '0;
                                jump_d = GROUND;
                            end else begin
                                y_d    = y_calc[COORD_W-1:0];
                                vel_d  = vel_eff - GRAV_S;
                                jump_d = AIR;
                            end
                        end
                        if (x_q <= COORD_W'(speed_cur)) begin
                            x_d     = START_C;
                            score_d = score_inc;
`ifdef SPEEDUP_EN
                            if (score_inc != score_q && score_inc[2:0] == 3'd0 &&
                                speed_q < SPEED_W'(SPEED_MAX))
                                speed_d = speed_q + SPEED_W'(1);
`endif
                        end else begin
                            x_d = x_q - COORD_W'(speed_cur);
                        end
                    end
                end
            end
            GAME_OVER: begin
                if (jump_pulse) begin
                    game_d      = RUN;
                    game_over_d = 1'b0;
                    jump_d      = GROUND;
                    vel_d       = '0;
                    y_d         = GROUND_C;
                    x_d         = START_C;
                    score_d     = '0;
                    jump_req_d  = 1'b0;
`ifdef SPEEDUP_EN
                    speed_d     = SPEED_INIT;
`endif
                end
            end
            default: game_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            game_q      <= IDLE;
            jump_q      <= GROUND;
            vel_q       <= '0;
            y_q         <= GROUND_C;
            x_q         <= START_C;
            score_q     <= '0;
            game_over_q <= 1'b0;
            jump_req_q  <= 1'b0;
`ifdef SPEEDUP_EN
            speed_q     <= SPEED_INIT;
`endif
        end else begin
            game_q      <= game_d;
            jump_q      <= jump_d;
            vel_q       <= vel_d;
            y_q         <= y_d;
            x_q         <= x_d;
            score_q     <= score_d;
            game_over_q <= game_over_d;
            jump_req_q  <= jump_req_d;
`ifdef SPEEDUP_EN
            speed_q     <= speed_d;
`endif
        end
    end

    assign x_coor          = 32'(DINO_X);
    assign y_coor          = 32'(y_q);
    assign x_coor_obstacle = 32'(x_q);
    assign y_coor_obstacle = 32'(GROUND_C);
    assign game_over       = game_over_q;
    assign score           = score_q;

endmodule

// File: tb/tb_dino_game_physics.sv
// Randomized self-checking bench for dino_game_physics against a frame-level model.
module tb_dino_game_physics;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        screen_ready = 1'b0;
    logic        collision_detected = 1'b0;
    logic        jump_btn = 1'b0;
    logic [31:0] x_coor, y_coor, x_coor_obstacle, y_coor_obstacle;
    logic        game_over;
    logic [15:0] score;

    int n_checks = 0;
    int n_fail   = 0;

    dino_game_physics dut (
        .clk                (clk),
        .reset              (reset),
        .screen_ready       (screen_ready),
        .collision_detected (collision_detected),
        .jump_btn           (jump_btn),
        .x_coor             (x_coor),
        .y_coor             (y_coor),
        .x_coor_obstacle    (x_coor_obstacle),
        .y_coor_obstacle    (y_coor_obstacle),
        .game_over          (game_over),
        .score              (score)
    );

    always #5 clk = ~clk;

    // Frame-level model: state 0 idle, 1 run, 2 over; jump height in closed form.
    int m_state, m_y, m_x, m_score, m_speed, m_t;
    bit m_air, m_pend;

    function automatic int height(input int t);
        return 14 * t - (t * (t - 1)) / 2;
    endfunction

    task automatic model_reset();
        m_state = 0; m_y = 320; m_x = 680; m_score = 0; m_speed = 4;
        m_t = 0; m_air = 0; m_pend = 0;
    endtask

    task automatic model_frame();
        int h;
        if (m_state != 1) return;
        if (!m_air && m_pend) begin
            m_air = 1; m_t = 0;
        end
        m_pend = 0;
        if (m_air) begin
            m_t++;
            h = height(m_t);
            if (h <= 0) begin
                m_y = 320; m_air = 0;
            end else begin
                m_y = 320 - h;
            end
        end
        if (m_x <= m_speed) begin
            m_x = 680;
            if (m_score < 65535) begin
                m_score++;
`ifdef SPEEDUP_EN
                if (m_score % 8 == 0 && m_speed < 12) m_speed++;
`endif
            end
        end else begin
            m_x = m_x - m_speed;
        end
    endtask

    task automatic model_press();
        case (m_state)
            0: m_state = 1;
            1: if (!m_air) m_pend = 1;
            default: begin
                m_state = 1; m_y = 320; m_x = 680; m_score = 0; m_speed = 4;
                m_t = 0; m_air = 0; m_pend = 0;
            end
        endcase
    endtask

    task automatic model_collide();
        if (m_state == 1) m_state = 2;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, "_x"},    x_coor, 32'd100);
        check_eq({tag, "_y"},    y_coor, 32'(m_y));
        check_eq({tag, "_ox"},   x_coor_obstacle, 32'(m_x));
        check_eq({tag, "_oy"},   y_coor_obstacle, 32'd320);
        check_eq({tag, "_over"}, 32'(game_over), 32'(m_state == 2));
        check_eq({tag, "_score"}, 32'(score), 32'(m_score));
    endtask

    // All drive tasks start and end on a falling edge.
    task automatic do_frame();
        screen_ready = 1'b1;
        repeat (4) @(negedge clk);
        screen_ready = 1'b0;
        repeat (4) @(negedge clk);
        model_frame();
    endtask

    task automatic do_frames(input int n);
        repeat (n) do_frame();
    endtask

    task automatic do_press();
        jump_btn = 1'b1;
        repeat (4) @(negedge clk);
        jump_btn = 1'b0;
        repeat (4) @(negedge clk);
        model_press();
    endtask

    task automatic do_collide();
        collision_detected = 1'b1;
        @(negedge clk);
        collision_detected = 1'b0;
        repeat (2) @(negedge clk);
        model_collide();
    endtask

    // Collision lands in the same clock as the frame tick.
    task automatic do_collide_tick();
        screen_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        collision_detected = 1'b1;
        @(negedge clk);
        collision_detected = 1'b0;
        repeat (2) @(negedge clk);
        screen_ready = 1'b0;
        repeat (4) @(negedge clk);
        model_collide();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    initial begin
        int guard;
        int r;
        int exp_step_x;
        model_reset();

        // Reset and idle hold.
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all("reset");
        do_frames(3);
        check_all("idle");
        check_eq("idle_ox_lit", x_coor_obstacle, 32'd680);

        // Start press does not jump; obstacle scrolls.
        do_press();
        do_frames(10);
        check_eq("run10_ox", x_coor_obstacle, 32'd640);
        check_eq("run10_y", y_coor, 32'd320);

        // Full jump arc, with a press while airborne.
        do_press();
        do_frame();
        check_eq("jump_t1", y_coor, 32'd306);
        do_frames(13);
        check_eq("jump_peak", y_coor, 32'd215);
        do_press();
        do_frames(15);
        check_eq("jump_land", y_coor, 32'd320);
        do_frame();
        check_eq("no_rejump", y_coor, 32'd320);
        check_all("after_jump");

        // Obstacle respawn and score.
        guard = 0;
        while (m_x != 4 && guard < 400) begin
            do_frame();
            guard++;
        end
        check_eq("obst_at4", x_coor_obstacle, 32'd4);
        do_frame();
        check_eq("respawn_ox", x_coor_obstacle, 32'd680);
        check_eq("respawn_score", 32'(score), 32'd1);

        // Collision coincident with a frame tick.
        do_collide_tick();
        check_all("coll_tick");
        check_eq("coll_over", 32'(game_over), 32'd1);
        do_frames(5);
        check_all("frozen");
        do_press();
        check_eq("restart_over", 32'(game_over), 32'd0);
        check_eq("restart_score", 32'(score), 32'd0);
        check_eq("restart_ox", x_coor_obstacle, 32'd680);

        // Randomized mix of frames, presses and collisions.
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 76)      do_frame();
            else if (r < 90) do_press();
            else if (r < 95) do_collide();
            else             do_collide_tick();
            check_all("rand");
        end

        // Reset mid-jump.
        do_reset(1);
        do_press();
        do_press();
        do_frames(6);
        check_eq("mid_jump_y", y_coor, 32'd251);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_y", y_coor, 32'd320);
        check_eq("rst_mid_ox", x_coor_obstacle, 32'd680);
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        do_frames(3);
        check_all("rst_idle");

        // Obstacle step after eight points.
        do_press();
        guard = 0;
        while (m_score < 8 && guard < 2000) begin
            do_frame();
            guard++;
        end
        check_eq("score8", 32'(score), 32'd8);
        do_frame();
`ifdef SPEEDUP_EN
        exp_step_x = 675;
`else
        exp_step_x = 676;
`endif
        check_eq("step_after8", x_coor_obstacle, 32'(exp_step_x));
        check_all("final");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
